core_wb_arb: RTL and testbench

CORE_WB_ARB -- requirements
Module: core_wb_arb

---
 rtl/core_wb_arb.sv | 157 +++++++++++++++
 tb/tb_core_wb_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/core_wb_arb.sv
// core_wb_arb: register-file writeback arbiter between the pipeline WB port
// and a single outstanding L1D load. Load returns win over pipeline writes;
// the pipeline is stalled on collisions, WAW hazards and second loads.
//
// Optional feature: define CORE_WB_ARB_TIMEOUT_EN to enable an 8-bit load
// timeout counter that abandons a load after 255 ack-less cycles and sets
// the sticky err_timeout_out flag. Undefined: loads wait forever, flag is 0.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pipe_we_in/rd/data     pipeline writeback request
//   ld_req_in/rd/sx_op     load issue (held while stall_out=1)
//   l1d_ack_in/data_in     L1D load return (one-cycle pulse)
//   rf_we/rd/data_out      registered register-file write port
//   stall_out              combinational pipeline stall
//   busy_vld/busy_rd_out   outstanding-load status
//   err_timeout_out        sticky load-timeout flag
module core_wb_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we_in,
  input  logic [4:0]  pipe_rd_in,
  input  logic [31:0] pipe_data_in,
  input  logic        ld_req_in,
  input  logic [4:0]  ld_rd_in,
  input  logic [2:0]  ld_sx_op_in,
  input  logic        l1d_ack_in,
  input  logic [31:0] l1d_data_in,
  output logic        rf_we_out,
  output logic [4:0]  rf_rd_out,
  output logic [31:0] rf_data_out,
  output logic        stall_out,
  output logic        busy_vld_out,
  output logic [4:0]  busy_rd_out,
  output logic        err_timeout_out
);

  typedef enum logic {ST_IDLE, ST_WAIT_ACK} state_t;

  state_t      r_state;
  logic [4:0]  r_ld_rd;
  logic [2:0]  r_ld_op;
  logic        r_rf_we;
  logic [4:0]  r_rf_rd;
  logic [31:0] r_rf_data;
  logic        r_busy_vld;
  logic [4:0]  r_busy_rd;

  logic [31:0] w_ld_data;
  logic        w_wait;
  logic        w_ack;
  logic        w_ld_wr;
  logic        w_pipe_nz;
  logic        w_stall;
  logic        w_pipe_wr;
  logic        w_timeout;

  always_comb begin
    w_ld_data = l1d_data_in;
    case (r_ld_op)
      3'd1:    w_ld_data = {24'h0, l1d_data_in[7:0]};
      3'd2:    w_ld_data = {{24{l1d_data_in[7]}}, l1d_data_in[7:0]};
      3'd3:    w_ld_data = {{16{l1d_data_in[15]}}, l1d_data_in[15:0]};
      3'd4:    w_ld_data = {16'h0, l1d_data_in[15:0]};
      default: w_ld_data = l1d_data_in;
    endcase
  end

  assign w_wait    = (r_state == ST_WAIT_ACK);
  assign w_ack     = w_wait & l1d_ack_in;
  // A returning load to x0 is not a real write, so it neither writes nor
  // blocks a concurrent pipeline write.
  assign w_ld_wr   = w_ack & (r_ld_rd != 5'd0);
  assign w_pipe_nz = pipe_we_in & (pipe_rd_in != 5'd0);
  assign w_stall   = ~rst & w_wait &
                     (ld_req_in | (w_pipe_nz & (w_ld_wr | (pipe_rd_in == r_ld_rd))));
  assign w_pipe_wr = w_pipe_nz & ~w_stall;
  assign stall_out = w_stall;

`ifdef CORE_WB_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  // Counter value 254 on an ack-less cycle means this is the 255th one.
  assign w_timeout = w_wait & ~l1d_ack_in & (r_cnt == 8'd254);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && ld_req_in)
        r_cnt <= '0;
      else if (w_wait && !l1d_ack_in)
        r_cnt <= r_cnt + 8'd1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign err_timeout_out = r_err;
`else
  assign w_timeout       = 1'b0;
  assign err_timeout_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ld_rd    <= '0;
      r_ld_op    <= '0;
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_data  <= '0;
      r_busy_vld <= 1'b0;
      r_busy_rd  <= '0;
    end else begin
      r_rf_we <= 1'b0;
      if (w_ld_wr) begin
        r_rf_we   <= 1'b1;
        r_rf_rd   <= r_ld_rd;
        r_rf_data <= w_ld_data;
      end else if (w_pipe_wr) begin
        r_rf_we   <= 1'b1;
        r_rf_rd   <= pipe_rd_in;
        r_rf_data <= pipe_data_in;
      end

      case (r_state)
        ST_IDLE: begin
          if (ld_req_in) begin
            r_state    <= ST_WAIT_ACK;
            r_ld_rd    <= ld_rd_in;
            r_ld_op    <= ld_sx_op_in;
            r_busy_vld <= 1'b1;
            r_busy_rd  <= ld_rd_in;
          end
        end
        ST_WAIT_ACK: begin
          if (l1d_ack_in || w_timeout) begin
            r_state    <= ST_IDLE;
            r_busy_vld <= 1'b0;
            r_busy_rd  <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rf_we_out    = r_rf_we;
  assign rf_rd_out    = r_rf_rd;
  assign rf_data_out  = r_rf_data;
  assign busy_vld_out = r_busy_vld;
  assign busy_rd_out  = r_busy_rd;

endmodule

// File: tb/tb_core_wb_arb.sv
module tb_core_wb_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we_in = 1'b0;
  logic [4:0]  pipe_rd_in = '0;
  logic [31:0] pipe_data_in = '0;
  logic        ld_req_in = 1'b0;
  logic [4:0]  ld_rd_in = '0;
  logic [2:0]  ld_sx_op_in = '0;
  logic        l1d_ack_in = 1'b0;
  logic [31:0] l1d_data_in = '0;
  logic        rf_we_out;
  logic [4:0]  rf_rd_out;
  logic [31:0] rf_data_out;
  logic        stall_out;
  logic        busy_vld_out;
  logic [4:0]  busy_rd_out;
  logic        err_timeout_out;

  core_wb_arb dut (
    .clk(clk), .rst(rst),
    .pipe_we_in(pipe_we_in), .pipe_rd_in(pipe_rd_in), .pipe_data_in(pipe_data_in),
    .ld_req_in(ld_req_in), .ld_rd_in(ld_rd_in), .ld_sx_op_in(ld_sx_op_in),
    .l1d_ack_in(l1d_ack_in), .l1d_data_in(l1d_data_in),
    .rf_we_out(rf_we_out), .rf_rd_out(rf_rd_out), .rf_data_out(rf_data_out),
    .stall_out(stall_out), .busy_vld_out(busy_vld_out), .busy_rd_out(busy_rd_out),
    .err_timeout_out(err_timeout_out)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: what the register file should see, from the rules.
  bit          m_busy;
  logic [4:0]  m_rd;
  logic [2:0]  m_op;
  int unsigned m_noack;
  bit          m_err;
  bit          m_we;
  logic [4:0]  m_wrd;
  logic [31:0] m_wdata;
  bit          m_stall;
  bit          seen_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] d);
    logic [31:0] b;
    case (op)
      3'd1: return d % 256;
      3'd2: begin b = d % 256;   return (b >= 128)   ? b + 32'hFFFF_FF00 : b; end
      3'd3: begin b = d % 65536; return (b >= 32768) ? b + 32'hFFFF_0000 : b; end
      3'd4: return d % 65536;
      default: return d;
    endcase
  endfunction

  task automatic step(input bit r, input bit pwe, input logic [4:0] prd, input logic [31:0] pd,
                      input bit lreq, input logic [4:0] lrd, input logic [2:0] lop,
                      input bit ack, input logic [31:0] ad);
    bit ack_now, ld_real, pipe_ok;
    @(negedge clk);
    rst = r; pipe_we_in = pwe; pipe_rd_in = prd; pipe_data_in = pd;
    ld_req_in = lreq; ld_rd_in = lrd; ld_sx_op_in = lop;
    l1d_ack_in = ack; l1d_data_in = ad;
    #1;
    m_we = 0;
    if (r) begin
      m_stall = 0; m_busy = 0; m_rd = '0; m_op = '0; m_noack = 0; m_err = 0;
      m_wrd = '0; m_wdata = '0;
    end else begin
      ack_now = m_busy && ack;
      ld_real = ack_now && (m_rd != 0);
      // Stall: second load, WAW on the pending rd, or collision with a real load return.
      m_stall = m_busy && (lreq || (pwe && prd != 0 && (ld_real || prd == m_rd)));
      pipe_ok = pwe && prd != 0 && !m_stall;
      if (ld_real) begin
        m_we = 1; m_wrd = m_rd; m_wdata = ext(m_op, ad);
      end else if (pipe_ok) begin
        m_we = 1; m_wrd = prd; m_wdata = pd;
      end
      if (!m_busy) begin
        if (lreq) begin m_busy = 1; m_rd = lrd; m_op = lop; m_noack = 0; end
      end else if (ack_now) begin
        m_busy = 0;
      end else begin
        m_noack++;
`ifdef CORE_WB_ARB_TIMEOUT_EN
        if (m_noack == 255) begin m_busy = 0; m_err = 1; end
`endif
      end
    end
    seen_stall = stall_out;
    chk("stall", {31'h0, stall_out}, {31'h0, m_stall});
    @(posedge clk);
    #1;
    chk("rf_we",    {31'h0, rf_we_out}, {31'h0, m_we});
    chk("rf_rd",    {27'h0, rf_rd_out}, {27'h0, m_wrd});
    chk("rf_data",  rf_data_out, m_wdata);
    chk("busy_vld", {31'h0, busy_vld_out}, {31'h0, m_busy});
    chk("busy_rd",  {27'h0, busy_rd_out}, {27'h0, (m_busy ? m_rd : 5'd0)});
    chk("err",      {31'h0, err_timeout_out}, {31'h0, m_err});
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  bit          s_pwe, s_lreq, s_ack, s_r;
  logic [4:0]  s_prd, s_lrd;
  logic [2:0]  s_lop;
  logic [31:0] s_pd, s_ad;

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_we", {31'h0, rf_we_out}, 32'h0);
    chk("rst_busy", {31'h0, busy_vld_out}, 32'h0);
    chk("rst_data", rf_data_out, 32'h0);

    // Signed byte load, ack after 3 cycles
    step(0, 0, 0, 0, 1, 5'd5, 3'd2, 0, 0);
    chk("t036_busy_rd", {27'h0, busy_rd_out}, 32'd5);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0080);
    chk("t036_we", {31'h0, rf_we_out}, 32'h1);
    chk("t036_rd", {27'h0, rf_rd_out}, 32'd5);
    chk("t036_data", rf_data_out, 32'hFFFF_FF80);
    chk("t036_busy", {31'h0, busy_vld_out}, 32'h0);
    idle(1);
    chk("t036_pulse", {31'h0, rf_we_out}, 32'h0);

    // Ack collides with pipeline write
    step(0, 0, 0, 0, 1, 5'd7, 3'd4, 0, 0);
    idle(1);
    step(0, 1, 5'd3, 32'hAA, 0, 0, 0, 1, 32'h1234_8001);
    chk("t037_stall", {31'h0, seen_stall}, 32'h1);
    chk("t037_rd", {27'h0, rf_rd_out}, 32'd7);
    chk("t037_data", rf_data_out, 32'h0000_8001);
    step(0, 1, 5'd3, 32'hAA, 0, 0, 0, 0, 0);
    chk("t037_stall2", {31'h0, seen_stall}, 32'h0);
    chk("t037_prd", {27'h0, rf_rd_out}, 32'd3);
    chk("t037_pdata", rf_data_out, 32'hAA);

    // WAW on pending rd
    step(0, 0, 0, 0, 1, 5'd9, 3'd0, 0, 0);
    step(0, 1, 5'd9, 32'h55, 0, 0, 0, 0, 0);
    chk("t038_stall", {31'h0, seen_stall}, 32'h1);
    chk("t038_nowr", {31'h0, rf_we_out}, 32'h0);
    step(0, 1, 5'd9, 32'h55, 0, 0, 0, 1, 32'h11);
    chk("t038_lddata", rf_data_out, 32'h11);
    step(0, 1, 5'd9, 32'h55, 0, 0, 0, 0, 0);
    chk("t038_pdata", rf_data_out, 32'h55);

    // rd=0 suppression
    step(0, 0, 0, 0, 1, 5'd0, 3'd0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t039_ldwe", {31'h0, rf_we_out}, 32'h0);
    step(0, 1, 5'd0, 32'h77, 0, 0, 0, 0, 0);
    chk("t039_pstall", {31'h0, seen_stall}, 32'h0);
    chk("t039_pwe", {31'h0, rf_we_out}, 32'h0);

    // Reset drops a pending load; ack in IDLE ignored
    step(0, 0, 0, 0, 1, 5'd12, 3'd0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1);
    chk("t040_we", {31'h0, rf_we_out}, 32'h0);
    chk("t040_busy", {31'h0, busy_vld_out}, 32'h0);

    // Long wait without ack
    step(0, 0, 0, 0, 1, 5'd4, 3'd0, 0, 0);
    idle(254);
    chk("to_err_early", {31'h0, err_timeout_out}, 32'h0);
    idle(1);
`ifdef CORE_WB_ARB_TIMEOUT_EN
    chk("to_err", {31'h0, err_timeout_out}, 32'h1);
    chk("to_idle", {31'h0, busy_vld_out}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h5);
    chk("to_nowr", {31'h0, rf_we_out}, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
`else
    idle(40);
    chk("to_still_busy", {31'h0, busy_vld_out}, 32'h1);
    chk("to_noerr", {31'h0, err_timeout_out}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h5);
    chk("to_late_ack", rf_data_out, 32'h5);
`endif

    // Randomized traffic; stalled inputs are held as the pipeline would.
    s_pwe = 0; s_prd = 0; s_pd = 0; s_lreq = 0; s_lrd = 0; s_lop = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      s_r = ($urandom_range(0, 99) == 0);
      if (!m_stall || s_r) begin
        s_pwe  = $urandom_range(0, 1);
        s_prd  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        s_pd   = $urandom;
        s_lreq = ($urandom_range(0, 3) == 0);
        s_lrd  = 5'($urandom_range(0, 3));
        s_lop  = 3'($urandom);
      end
      s_ack = ($urandom_range(0, 3) == 0);
      s_ad  = $urandom;
      step(s_r, s_pwe, s_prd, s_pd, s_lreq, s_lrd, s_lop, s_ack, s_ad);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
